// File: rtl/hazard_unit.sv
// Stall/forwarding controller for the 5-stage MIPS pipeline.
// It keeps a shadow copy of every in-flight writer in E/M/W, stalls D when an operand
// cannot be produced in time, and drives the D/E/M forwarding mux selects.
// Optional feature: define HAZARD_STALL_CNT_EN to build the 32-bit stall-cycle counter;
// otherwise stall_cnt is tied to zero and no counter flops exist.
module hazard_unit #(
  parameter int unsigned TNEW_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        D_rs,
  input  logic [4:0]        D_rt,
  input  logic              D_use_rs,
  input  logic              D_use_rt,
  input  logic [TNEW_W-1:0] D_Tuse_rs,
  input  logic [TNEW_W-1:0] D_Tuse_rt,
  input  logic [4:0]        D_A3,
  input  logic              D_RegWrite,
  input  logic [TNEW_W-1:0] D_Tnew,
  output logic              stall,
  output logic [1:0]        D_fwd_rs,
  output logic [1:0]        D_fwd_rt,
  output logic [1:0]        E_fwd_rs,
  output logic [1:0]        E_fwd_rt,
  output logic              M_fwd_rt,
  output logic [31:0]       stall_cnt
);

  // Forward select encodings
  localparam logic [1:0] FwdNone = 2'b00;
  localparam logic [1:0] FwdE    = 2'b01;
  localparam logic [1:0] FwdM    = 2'b10;
  localparam logic [1:0] FwdW    = 2'b11;

  // Saturating decrement: Tnew never goes below zero as an instruction ages.
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    sat_dec = (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  // A stage can forward to a reader only if it writes a non-$0 match and the value exists.
  function automatic logic fwd_hit(input logic              src_we,
                                   input logic [4:0]        src_a3,
                                   input logic [TNEW_W-1:0] src_tnew,
                                   input logic [4:0]        addr);
    fwd_hit = src_we && (src_a3 == addr) && (addr != 5'd0) && (src_tnew == '0);
  endfunction

  // A stage forces a stall when its pending result is later than the reader's deadline.
  function automatic logic late_hit(input logic              src_we,
                                    input logic [4:0]        src_a3,
                                    input logic [TNEW_W-1:0] src_tnew,
                                    input logic [4:0]        addr,
                                    input logic [TNEW_W-1:0] tuse);
    late_hit = src_we && (src_a3 == addr) && (src_tnew > tuse);
  endfunction

  // Shadow pipeline state
  logic [4:0]        e_a3_q, e_a3_d;
  logic              e_we_q, e_we_d;
  logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
  logic [4:0]        e_rs_q, e_rs_d;
  logic [4:0]        e_rt_q, e_rt_d;

  logic [4:0]        m_a3_q, m_a3_d;
  logic              m_we_q, m_we_d;
  logic [TNEW_W-1:0] m_tnew_q, m_tnew_d;
  logic [4:0]        m_rt_q, m_rt_d;

  logic [4:0]        w_a3_q, w_a3_d;
  logic              w_we_q, w_we_d;
  logic [TNEW_W-1:0] w_tnew_q, w_tnew_d;

  logic stall_rs, stall_rt;

  // Stall detection: only E and M can still be producing; W always has its value.
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    if (D_use_rs && (D_rs != 5'd0)) begin
      stall_rs = late_hit(e_we_q, e_a3_q, e_tnew_q, D_rs, D_Tuse_rs) ||
                 late_hit(m_we_q, m_a3_q, m_tnew_q, D_rs, D_Tuse_rs);
    end
    if (D_use_rt && (D_rt != 5'd0)) begin
      stall_rt = late_hit(e_we_q, e_a3_q, e_tnew_q, D_rt, D_Tuse_rt) ||
                 late_hit(m_we_q, m_a3_q, m_tnew_q, D_rt, D_Tuse_rt);
    end
    stall = stall_rs | stall_rt;
  end

  // Next-state of the shadow pipeline: bubble into E on stall, M and W always advance.
  always_comb begin
    e_a3_d   = '0;
    e_we_d   = 1'b0;
    e_tnew_d = '0;
    e_rs_d   = '0;
    e_rt_d   = '0;
    if (!stall) begin
      e_a3_d   = D_A3;
      e_we_d   = D_RegWrite && (D_A3 != 5'd0);
      e_tnew_d = sat_dec(D_Tnew);
      e_rs_d   = D_rs;
      e_rt_d   = D_rt;
    end
    m_a3_d   = e_a3_q;
    m_we_d   = e_we_q;
    m_tnew_d = sat_dec(e_tnew_q);
    m_rt_d   = e_rt_q;
    w_a3_d   = m_a3_q;
    w_we_d   = m_we_q;
    w_tnew_d = '0;
  end

  // Shadow pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_a3_q   <= '0;
      e_we_q   <= 1'b0;
      e_tnew_q <= '0;
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      m_a3_q   <= '0;
      m_we_q   <= 1'b0;
      m_tnew_q <= '0;
      m_rt_q   <= '0;
      w_a3_q   <= '0;
      w_we_q   <= 1'b0;
      w_tnew_q <= '0;
    end else begin
      e_a3_q   <= e_a3_d;
      e_we_q   <= e_we_d;
      e_tnew_q <= e_tnew_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      m_a3_q   <= m_a3_d;
      m_we_q   <= m_we_d;
      m_tnew_q <= m_tnew_d;
      m_rt_q   <= m_rt_d;
      w_a3_q   <= w_a3_d;
      w_we_q   <= w_we_d;
      w_tnew_q <= w_tnew_d;
    end
  end

  // D-stage forwarding: youngest ready producer wins (E > M > W); valid while stalled.
  always_comb begin
    D_fwd_rs = FwdNone;
    if (fwd_hit(e_we_q, e_a3_q, e_tnew_q, D_rs)) begin
      D_fwd_rs = FwdE;
    end else if (fwd_hit(m_we_q, m_a3_q, m_tnew_q, D_rs)) begin
      D_fwd_rs = FwdM;
    end else if (fwd_hit(w_we_q, w_a3_q, w_tnew_q, D_rs)) begin
      D_fwd_rs = FwdW;
    end

    D_fwd_rt = FwdNone;
    if (fwd_hit(e_we_q, e_a3_q, e_tnew_q, D_rt)) begin
      D_fwd_rt = FwdE;
    end else if (fwd_hit(m_we_q, m_a3_q, m_tnew_q, D_rt)) begin
      D_fwd_rt = FwdM;
    end else if (fwd_hit(w_we_q, w_a3_q, w_tnew_q, D_rt)) begin
      D_fwd_rt = FwdW;
    end
  end

  // E-stage forwarding (M > W) and M-stage store-data forwarding from W.
  always_comb begin
    E_fwd_rs = FwdNone;
    if (fwd_hit(m_we_q, m_a3_q, m_tnew_q, e_rs_q)) begin
      E_fwd_rs = FwdM;
    end else if (fwd_hit(w_we_q, w_a3_q, w_tnew_q, e_rs_q)) begin
      E_fwd_rs = FwdW;
    end

    E_fwd_rt = FwdNone;
    if (fwd_hit(m_we_q, m_a3_q, m_tnew_q, e_rt_q)) begin
      E_fwd_rt = FwdM;
    end else if (fwd_hit(w_we_q, w_a3_q, w_tnew_q, e_rt_q)) begin
      E_fwd_rt = FwdW;
    end

    M_fwd_rt = fwd_hit(w_we_q, w_a3_q, w_tnew_q, m_rt_q);
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Stall-cycle counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
